// File: rtl/binning_kxk.sv
`timescale 1ns/1ps
// binning_kxk: KxK pixel binning of a raster stream into one thresholded (or mean) pixel per bin
//
// Optional feature macro: BINNING_MEAN_EN
//   Defined     -> mode_in selects threshold (0) or mean (1) output.
//   Not defined -> mode_in is ignored and the output is always thresholded.
//
// Ports
//   clk_in          single system clock
//   rst_n_in        asynchronous active-low reset
//   hcount_in       x coordinate of the current pixel
//   vcount_in       y coordinate of the current pixel
//   pixel_data_in   incoming unsigned pixel
//   data_valid_in   qualifies pixel_data_in / hcount_in / vcount_in
//   threshold_in    binarisation threshold, sampled with the bottom-right pixel of a bin
//   mode_in         0 = threshold, 1 = mean (mean build only)
//   pixel_data_out  binned pixel, held until the next strobe
//   hcount_out      bin column of the emitted pixel
//   vcount_out      bin row of the emitted pixel
//   data_valid_out  one-cycle strobe per completed bin, 3 cycles after its bottom-right pixel
module binning_kxk #(
    parameter int HRES        = 1280,
    parameter int VRES        = 720,
    parameter int DATA_WIDTH  = 1,
    parameter int KERNEL_LOG2 = 2,
    localparam int HWIDTH     = $clog2(HRES),
    localparam int VWIDTH     = $clog2(VRES),
    localparam int ACC_WIDTH  = DATA_WIDTH + 2*KERNEL_LOG2
) (
    input  logic                          clk_in,
    input  logic                          rst_n_in,
    input  logic [HWIDTH-1:0]             hcount_in,
    input  logic [VWIDTH-1:0]             vcount_in,
    input  logic [DATA_WIDTH-1:0]         pixel_data_in,
    input  logic                          data_valid_in,
    input  logic [ACC_WIDTH-1:0]          threshold_in,
    input  logic                          mode_in,
    output logic [DATA_WIDTH-1:0]         pixel_data_out,
    output logic [HWIDTH-KERNEL_LOG2-1:0] hcount_out,
    output logic [VWIDTH-KERNEL_LOG2-1:0] vcount_out,
    output logic                          data_valid_out
);
    localparam int BW    = HWIDTH - KERNEL_LOG2;
    localparam int BVW   = VWIDTH - KERNEL_LOG2;
    localparam int DEPTH = HRES >> KERNEL_LOG2;

    logic [KERNEL_LOG2-1:0] hlow, vlow;
    logic                   last_col, first_row, last_row, commit;
    logic [ACC_WIDTH-1:0]   row_sum_d, entry, full_d;
    logic [DATA_WIDTH-1:0]  result_d;

    // column-sum RAM: one entry per bin column, intentionally not reset
    logic [ACC_WIDTH-1:0]   mem_q [DEPTH];

    logic [ACC_WIDTH-1:0]   hacc_q;
    logic                   primed_q;

    logic                   s1_vld_q, s1_first_q, s1_last_q;
    logic [ACC_WIDTH-1:0]   s1_sum_q, s1_thr_q;
    logic [BW-1:0]          s1_addr_q;
    logic [BVW-1:0]         s1_vbin_q;

    logic                   s2_vld_q;
    logic [ACC_WIDTH-1:0]   s2_sum_q, s2_thr_q;
    logic [BW-1:0]          s2_hbin_q;
    logic [BVW-1:0]         s2_vbin_q;

    assign hlow      = hcount_in[KERNEL_LOG2-1:0];
    assign vlow      = vcount_in[KERNEL_LOG2-1:0];
    assign last_col  = &hlow;
    assign first_row = (vlow == '0);
    assign last_row  = &vlow;

    // horizontal accumulator restarts on the first column of every bin
    assign row_sum_d = ((hlow == '0) ? '0 : hacc_q) + ACC_WIDTH'(pixel_data_in);

    // After reset the RAM holds stale sums, so nothing is committed until a
    // row-0 line has been seen from its very first pixel.
    assign commit = data_valid_in && last_col && primed_q;

    // row 0 of a bin row starts from zero, so stale entries never leak in
    assign entry  = mem_q[s1_addr_q];
    assign full_d = (s1_first_q ? '0 : entry) + s1_sum_q;

`ifdef BINNING_MEAN_EN
    logic s1_mode_q, s2_mode_q;
    // dividing by K*K leaves exactly the top DATA_WIDTH bits of the sum
    assign result_d = s2_mode_q ? s2_sum_q[ACC_WIDTH-1 -: DATA_WIDTH]
                                : {DATA_WIDTH{s2_sum_q > s2_thr_q}};
`else
    logic unused_mode;
    assign unused_mode = mode_in;
    assign result_d    = {DATA_WIDTH{s2_sum_q > s2_thr_q}};
`endif

    always_ff @(posedge clk_in) begin
        if (s1_vld_q && !s1_last_q) mem_q[s1_addr_q] <= full_d;
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            hacc_q         <= '0;
            primed_q       <= 1'b0;
            s1_vld_q       <= 1'b0;
            s1_first_q     <= 1'b0;
            s1_last_q      <= 1'b0;
            s1_sum_q       <= '0;
            s1_thr_q       <= '0;
            s1_addr_q      <= '0;
            s1_vbin_q      <= '0;
            s2_vld_q       <= 1'b0;
            s2_sum_q       <= '0;
            s2_thr_q       <= '0;
            s2_hbin_q      <= '0;
            s2_vbin_q      <= '0;
`ifdef BINNING_MEAN_EN
            s1_mode_q      <= 1'b0;
            s2_mode_q      <= 1'b0;
`endif
            data_valid_out <= 1'b0;
            pixel_data_out <= '0;
            hcount_out     <= '0;
            vcount_out     <= '0;
        end else begin
            if (data_valid_in) hacc_q <= row_sum_d;
            if (data_valid_in && hcount_in == '0 && first_row) primed_q <= 1'b1;
            s1_vld_q <= commit;
            if (commit) begin
                s1_sum_q   <= row_sum_d;
                s1_thr_q   <= threshold_in;
                s1_addr_q  <= hcount_in[HWIDTH-1:KERNEL_LOG2];
                s1_vbin_q  <= vcount_in[VWIDTH-1:KERNEL_LOG2];
                s1_first_q <= first_row;
                s1_last_q  <= last_row;
`ifdef BINNING_MEAN_EN
                s1_mode_q  <= mode_in;
`endif
            end
            s2_vld_q <= s1_vld_q && s1_last_q;
            if (s1_vld_q && s1_last_q) begin
                s2_sum_q  <= full_d;
                s2_thr_q  <= s1_thr_q;
                s2_hbin_q <= s1_addr_q;
                s2_vbin_q <= s1_vbin_q;
`ifdef BINNING_MEAN_EN
                s2_mode_q <= s1_mode_q;
`endif
            end
            data_valid_out <= s2_vld_q;
            if (s2_vld_q) begin
                pixel_data_out <= result_d;
                hcount_out     <= s2_hbin_q;
                vcount_out     <= s2_vbin_q;
            end
        end
    end
endmodule

// File: tb/tb_binning_kxk.sv
`timescale 1ns/1ps
// tb_binning_kxk: randomized frames checked against a per-bin arithmetic model of binning_kxk
module tb_binning_kxk;
`ifdef BINNING_MEAN_EN
    localparam int DW   = 8;
    localparam bit MEAN = 1'b1;
`else
    localparam int DW   = 1;
    localparam bit MEAN = 1'b0;
`endif
    localparam int KL   = 2;
    localparam int K    = 4;
    localparam int HR   = 8;
    localparam int VR   = 8;
    localparam int HW   = 3;
    localparam int VW   = 3;
    localparam int AW   = DW + 2*KL;
    localparam int MAXP = (1 << DW) - 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [HW-1:0] hcount = '0;
    logic [VW-1:0] vcount = '0;
    logic [DW-1:0] pix = '0;
    logic          valid = 1'b0;
    logic [AW-1:0] thr_in = '0;
    logic          mode = 1'b0;
    logic [DW-1:0] pixel_data_out;
    logic [HW-KL-1:0] hcount_out;
    logic [VW-KL-1:0] vcount_out;
    logic          data_valid_out;

    binning_kxk #(.HRES(HR), .VRES(VR), .DATA_WIDTH(DW), .KERNEL_LOG2(KL)) dut (
        .clk_in(clk), .rst_n_in(rst_n), .hcount_in(hcount), .vcount_in(vcount),
        .pixel_data_in(pix), .data_valid_in(valid), .threshold_in(thr_in), .mode_in(mode),
        .pixel_data_out(pixel_data_out), .hcount_out(hcount_out), .vcount_out(vcount_out),
        .data_valid_out(data_valid_out)
    );

    always #5 clk = ~clk;

    typedef struct {int e; logic [DW-1:0] p; int h; int v;} exp_t;
    exp_t          q[$];
    logic [DW-1:0] got[$];
    logic [DW-1:0] frame [VR][HR];
    int checks = 0, failures = 0, pcnt = 0;
    int gap_mode = 0, thr_fixed = -1, mode_fixed = -1, trunc_y = -1;
    logic [DW-1:0] last_p = '0;
    logic [HW-KL-1:0] last_h = '0;
    logic [VW-KL-1:0] last_v = '0;

    always @(posedge clk) pcnt <= pcnt + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d (edge %0d)", name, act, exp, pcnt);
        end
    endtask

    // expected bin value straight from the frame contents
    function automatic logic [DW-1:0] bin_out(input int bx, input int by, input int thr, input bit m);
        int s = 0;
        for (int j = 0; j < K; j++)
            for (int i = 0; i < K; i++)
                s += int'(frame[by*K+j][bx*K+i]);
        if (MEAN && m) return DW'(s / (K*K));
        return (s > thr) ? {DW{1'b1}} : '0;
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            last_p = '0;
            last_h = '0;
            last_v = '0;
        end
        while (q.size() != 0 && q[0].e < pcnt) begin
            check("missing_strobe", 64'(q[0].h * 16 + q[0].v), 64'hFFFF);
            void'(q.pop_front());
        end
        if (data_valid_out) begin
            got.push_back(pixel_data_out);
            if (q.size() == 0) begin
                check("unexpected_strobe", 64'(pcnt), 64'hFFFF_FFFF);
            end else begin
                exp_t x;
                x = q.pop_front();
                check("strobe_edge", 64'(pcnt), 64'(x.e));
                check("pixel_out", 64'(pixel_data_out), 64'(x.p));
                check("bin_coord", 64'({hcount_out, vcount_out}), 64'(x.h * 2 + x.v));
            end
            last_p = pixel_data_out;
            last_h = hcount_out;
            last_v = vcount_out;
        end else begin
            check("hold", 64'({pixel_data_out, hcount_out, vcount_out}), 64'({last_p, last_h, last_v}));
        end
    end

    task automatic drive(input int x, input int y, input bit exp_on);
        int thr, n;
        bit m;
        thr    = (thr_fixed >= 0) ? thr_fixed : int'($urandom_range(0, K*K*MAXP));
        m      = (mode_fixed >= 0) ? (mode_fixed != 0) : 1'($urandom);
        hcount = HW'(x);
        vcount = VW'(y);
        pix    = frame[y][x];
        valid  = 1'b1;
        thr_in = AW'(thr);
        mode   = m;
        @(posedge clk); #1;
        if (exp_on && x % K == K-1 && y % K == K-1)
            q.push_back('{pcnt + 2, bin_out(x/K, y/K, thr, m), x/K, y/K});
        n = (gap_mode == 0) ? 0 : (gap_mode == 1) ? 1 : int'($urandom_range(0, 2));
        repeat (n) begin
            valid  = 1'b0;
            pix    = DW'($urandom);
            thr_in = AW'($urandom);
            mode   = 1'($urandom);
            @(posedge clk); #1;
        end
        valid = 1'b0;
    endtask

    task automatic send_rows(input int y0, input int y1, input bit exp_on);
        for (int y = y0; y <= y1; y++)
            for (int x = 0; x < ((y == trunc_y) ? HR - 2 : HR); x++)
                drive(x, y, exp_on);
    endtask

    task automatic drain();
        repeat (6) @(posedge clk);
        #1;
    endtask

    task automatic fill_rand();
        for (int y = 0; y < VR; y++)
            for (int x = 0; x < HR; x++)
                frame[y][x] = DW'($urandom);
    endtask

    task automatic fill_const(input logic [DW-1:0] v);
        for (int y = 0; y < VR; y++)
            for (int x = 0; x < HR; x++)
                frame[y][x] = v;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_valid", 64'(data_valid_out), 64'd0);
        check("reset_pixel", 64'(pixel_data_out), 64'd0);
        check("reset_hcount", 64'(hcount_out), 64'd0);
        check("reset_vcount", 64'(vcount_out), 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // all-ones frame, threshold 8: four bins, all saturated
        thr_fixed = 8; mode_fixed = 0; gap_mode = 0;
        fill_const({DW{1'b1}});
        base = got.size();
        send_rows(0, VR-1, 1'b1);
        drain();
        check("ones_strobes", 64'(got.size() - base), 64'd4);
        check("ones_first", 64'(got[base]), 64'(MAXP));
        check("ones_last_pixel", 64'(pixel_data_out), 64'(MAXP));
        check("ones_last_coord", 64'({hcount_out, vcount_out}), 64'd3);

        // 8 ones then 9 ones against threshold 8
        fill_const('0);
        for (int y = 0; y < 2; y++)
            for (int x = 0; x < HR; x++)
                frame[y][x] = 1;
        frame[2][4] = 1;
        base = got.size();
        send_rows(0, VR-1, 1'b1);
        drain();
        check("eight_ones", 64'(got[base]), 64'd0);
        check("nine_ones", 64'(got[base+1]), 64'(MAXP));

        // next frame all zeros: no residue from the previous frame
        fill_const('0);
        base = got.size();
        send_rows(0, VR-1, 1'b1);
        drain();
        check("zero_frame_first", 64'(got[base]), 64'd0);
        check("zero_frame_last", 64'(got[base+3]), 64'd0);

`ifdef BINNING_MEAN_EN
        mode_fixed = 1;
        fill_const(DW'(200));
        base = got.size();
        send_rows(0, VR-1, 1'b1);
        drain();
        for (int i = 0; i < 4; i++) check("mean_200", 64'(got[base+i]), 64'd200);
        fill_const('0);
        for (int y = 0; y < K; y++)
            for (int x = 0; x < K; x++)
                frame[y][x] = DW'(y*K + x);
        base = got.size();
        send_rows(0, VR-1, 1'b1);
        drain();
        check("mean_ramp", 64'(got[base]), 64'd7);
`endif

        // same random frame contiguous then with 1-0-1 valid toggling, then random gaps
        thr_fixed = -1; mode_fixed = -1;
        fill_rand();
        for (int g = 0; g < 3; g++) begin
            gap_mode = g;
            send_rows(0, VR-1, 1'b1);
        end
        for (int f = 0; f < 4; f++) begin
            gap_mode = f % 3;
            fill_rand();
            send_rows(0, VR-1, 1'b1);
        end
        drain();

        // last row of a bin row ends mid-bin: that bin is dropped
        gap_mode = 0;
        fill_rand();
        trunc_y = 3;
        base = got.size();
        send_rows(0, VR-1, 1'b1);
        drain();
        trunc_y = -1;
        check("trunc_strobes", 64'(got.size() - base), 64'd3);

        // reset at row 2 of the first bin row
        fill_rand();
        send_rows(0, 1, 1'b0);
        for (int x = 0; x < 5; x++) drive(x, 2, 1'b0);
        rst_n = 1'b0;
        #1;
        check("midreset_valid", 64'(data_valid_out), 64'd0);
        check("midreset_pixel", 64'(pixel_data_out), 64'd0);
        check("midreset_coord", 64'({hcount_out, vcount_out}), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        base = got.size();
        for (int x = 5; x < HR; x++) drive(x, 2, 1'b0);
        send_rows(3, 3, 1'b0);
        drain();
        check("midreset_no_strobe", 64'(got.size() - base), 64'd0);
        send_rows(4, VR-1, 1'b1);
        fill_rand();
        gap_mode = 2;
        send_rows(0, VR-1, 1'b1);
        drain();
        check("pending_strobes", 64'(q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/binning_kxk.md
BINNING_KXK -- requirements
Module: binning_kxk

Interface
REQ-001 SHALL have parameter HRES, default 1280, meaning input frame width in pixels; must be a multiple of 2**KERNEL_LOG2.
REQ-002 SHALL have parameter VRES, default 720, meaning input frame height in pixels; must be a multiple of 2**KERNEL_LOG2.
REQ-003 SHALL have parameter DATA_WIDTH, default 1, meaning the unsigned pixel width.
REQ-004 SHALL have parameter KERNEL_LOG2, default 2, meaning log2 of the kernel edge K (K=4 by default).
REQ-005 SHALL derive HWIDTH=$clog2(HRES), VWIDTH=$clog2(VRES) and ACC_WIDTH=DATA_WIDTH+2*KERNEL_LOG2.
REQ-006 SHALL have port clk_in, input, 1 bit, the single system clock.
REQ-007 SHALL have port rst_n_in, input, 1 bit, asynchronous active-low reset.
REQ-008 SHALL have ports hcount_in/vcount_in, input, HWIDTH/VWIDTH bits, the coordinates of the current pixel.
REQ-009 SHALL have port pixel_data_in, input, DATA_WIDTH bits, the incoming pixel.
REQ-010 SHALL have port data_valid_in, input, 1 bit, qualifying the incoming pixel.
REQ-011 SHALL have port threshold_in, input, ACC_WIDTH bits, the binarisation threshold, sampled with the bottom-right pixel of each bin.
REQ-012 SHALL have port mode_in, input, 1 bit: 0=threshold, 1=mean.
REQ-013 SHALL have port pixel_data_out, output, DATA_WIDTH bits, the binned pixel.
REQ-014 SHALL have ports hcount_out/vcount_out, output, HWIDTH-KERNEL_LOG2/VWIDTH-KERNEL_LOG2 bits, the bin coordinates.
REQ-015 SHALL have port data_valid_out, output, 1 bit, a single-cycle strobe per completed bin.

Function
REQ-016 SHALL accept pixels in raster order, with arbitrary gaps in data_valid_in; pixels with data_valid_in low are ignored.
REQ-017 SHALL sum the K pixels of each bin row in a horizontal accumulator that is cleared at hcount_in[KERNEL_LOG2-1:0]==0.
REQ-018 SHALL keep one column-sum accumulator RAM, HRES/K deep and ACC_WIDTH wide, with exactly one access per K pixels, so there are no read-modify-write hazards.
REQ-019 SHALL, on bin rows with vcount_in[KERNEL_LOG2-1:0]==0, overwrite the bin entry; on middle rows it SHALL add to the entry; on row K-1 it SHALL read the entry and emit without a write.
REQ-020 SHALL compute the full sum S = entry + row sum at full ACC_WIDTH precision, with no overflow possible.
REQ-021 SHALL, in threshold mode, output all-ones when S > threshold_in and zero otherwise.
REQ-022 SHALL, in mean mode, output S >> (2*KERNEL_LOG2).
REQ-023 SHALL assert data_valid_out exactly 3 clk_in cycles after the bottom-right pixel (hcount and vcount low bits all ones) is accepted.
REQ-024 SHALL hold pixel_data_out, hcount_out and vcount_out stable until the next strobe.
REQ-025 SHALL set hcount_out=hcount_in>>KERNEL_LOG2 and vcount_out=vcount_in>>KERNEL_LOG2 for the emitting pixel.
REQ-026 SHALL allow back-to-back bin completions every K cycles with no stalls, and SHALL have no backpressure.
REQ-027 SHALL start the next frame cleanly when vcount_in wraps from VRES-1 to 0, because row-0 overwrite makes stale RAM content irrelevant.
REQ-028 SHALL discard the partial bin when a row ends mid-bin (hcount jump); no strobe is produced for it.

Reset
REQ-029 SHALL, while rst_n_in is low, asynchronously force data_valid_out=0, pixel_data_out=0, hcount_out=0, vcount_out=0, clear the accumulators and flush the pipeline valids.
REQ-030 SHALL NOT clear RAM contents on reset.
REQ-031 SHALL, after a mid-frame reset, produce no strobe until a bin has been fully re-accumulated starting from a row where vcount_in[KERNEL_LOG2-1:0]==0.

Configuration
REQ-032 SHALL compile in mean mode when macro BINNING_MEAN_EN is defined.
REQ-033 SHALL, without BINNING_MEAN_EN, ignore mode_in, always use threshold mode, and omit the shifter and mode mux.

Verification
REQ-034 SHALL cover: K=4, DATA_WIDTH=1, threshold 8, all-ones 8x8 frame -> 4 strobes, each output 1, bins (0,0),(1,0),(0,1),(1,1).
REQ-035 SHALL cover: K=4, one bin containing exactly 8 ones then another containing 9 ones, threshold 8 -> outputs 0 then 1.
REQ-036 SHALL cover: BINNING_MEAN_EN, DATA_WIDTH=8, mode 1, all pixels 200 -> every output 200; pixels 0..15 in one bin -> output 7.
REQ-037 SHALL cover: data_valid_in toggling 1-0-1 every cycle -> identical outputs to the contiguous stream, each strobe 3 cycles after the bottom-right pixel.
REQ-038 SHALL cover: rst_n_in pulsed low at row 2 of a bin row -> outputs 0 immediately, no strobe for the interrupted bins, and correct bins from the next aligned row.
REQ-039 SHALL cover: two consecutive frames with different content -> the second frame's outputs carry no residue from the first.
